fifo_drain_arbiter: RTL and testbench
=====================================

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6, sets the width of each FIFO data word and of data_out.
REQ-002 Parameter BURST_LEN, default 4, sets the maximum number of consecutive reads granted to one channel (range 1..15).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset; synchronous, active-low.
REQ-005 fifo_empty  input  4  per-channel empty flag from upstream FIFOs 0..3.
REQ-006 fifo_error  input  4  per-channel overflow/underflow error flag from upstream FIFOs.
REQ-007 fifo_data_0..fifo_data_3  input  DATA_WIDTH each  registered read data of FIFO 0..3.
REQ-008 pause  input  1  downstream almost-full; 1 = issue no new reads.
REQ-009 fifo_rd_enable  output  4  per-channel pop strobe, one-hot or zero.
REQ-010 data_out  output  DATA_WIDTH  drained word, registered.
REQ-011 valid_out  output  1  data_out/dest_out valid this cycle.
REQ-012 dest_out  output  2  source channel index of data_out.
REQ-013 idle  output  1  1 when state is IDLE and no read is in flight.
REQ-014 error_out  output  1  sticky error indication.

Function
REQ-015 FSM states: IDLE, READ, ERROR, registered; rd_enable is combinational from state and current inputs.
REQ-016 Upstream FIFO read latency: pop strobe in cycle N, the FIFO presents the word during N+1.
REQ-017 fifo_rd_enable[ch] = 1 only when state=READ, fifo_empty[ch]=0, pause=0, burst_cnt<BURST_LEN; all other bits 0.
REQ-018 Each issued pop sets an in-flight stage (pend_valid=1, pend_ch=ch) at the end of cycle N.
REQ-019 When pend_valid=1 in cycle N+1, data_out<=fifo_data_[pend_ch], dest_out<=pend_ch, valid_out<=1; valid_out is high in cycle N+2 (latency 2), else valid_out<=0 with data_out/dest_out held.
REQ-020 Back-to-back pops on one channel give valid_out high on consecutive cycles (throughput 1 word/cycle).
REQ-021 IDLE: when any fifo_empty bit is 0 and pause=0, select ch = first non-empty channel scanning rr_ptr, rr_ptr+1, ... mod 4; go READ; burst_cnt<=0; no pop in the IDLE cycle.
REQ-022 READ: each pop increments burst_cnt (width 4).
REQ-023 READ exit: when burst_cnt=BURST_LEN, or fifo_empty[ch]=1 with pause=0, go IDLE and set rr_ptr<=ch+1 mod 4.
REQ-024 READ with pause=1: no pop, stay in READ, burst_cnt and ch held; the in-flight word still completes per REQ-019.
REQ-025 Last word: after a pop that empties the FIFO, fifo_empty=1 the next cycle and REQ-023 applies; no pop on an empty FIFO.
REQ-026 Any fifo_error bit = 1 in IDLE or READ: go ERROR next cycle, no pop in that cycle; the in-flight word completes.
REQ-027 ERROR is absorbing until reset: error_out=1, fifo_rd_enable=0.
REQ-028 idle = (state=IDLE) and pend_valid=0 and valid_out=0.

Reset
REQ-029 With reset=0 at a rising edge: state<=IDLE, rr_ptr<=0, burst_cnt<=0, ch<=0, pend_valid<=0, data_out<=0, dest_out<=0, valid_out<=0, error_out<=0.
REQ-030 During reset=0, fifo_rd_enable=0 regardless of inputs.
REQ-031 A reset mid-burst discards the in-flight word; valid_out=0 in the first cycle after reset release.

Verification
REQ-032 Single word: FIFO2 holds 0x15, others empty -> one pop on bit2; valid_out=1 two cycles after the pop, data_out=0x15, dest_out=2; then idle=1.
REQ-033 Burst limit: FIFO0 holds 6 words, BURST_LEN=4 -> 4 consecutive pops on ch0, IDLE turnaround cycle, then 2 more pops; 6 valid_out cycles in original order.
REQ-034 Round robin: FIFO0 and FIFO1 each hold 5 words -> ch0 gets 4 pops, ch1 gets 4 pops, ch0 1 pop, ch1 1 pop; dest_out sequence 0,0,0,0,1,1,1,1,0,1.
REQ-035 Pause: assert pause for 3 cycles after the second pop of a burst -> no pops during pause, in-flight word still delivered, burst resumes with the remaining 2 pops.
REQ-036 Error: raise fifo_error[3] mid-burst on ch1 -> pops stop the next cycle, error_out=1 sticky, rd_enable stays 0 until reset=0 clears it.
REQ-037 Reset mid-operation: reset=0 one cycle after a pop -> valid_out stays 0, all outputs at reset values, rr_ptr=0 on release.

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain arbiter for four upstream FIFOs with registered (1-cycle) read data.
// Grants bursts of up to BURST_LEN pops per channel and forwards words with 2-cycle latency.
module fifo_drain_arbiter #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            fifo_empty,
  input  logic [3:0]            fifo_error,
  input  logic [DATA_WIDTH-1:0] fifo_data_0,
  input  logic [DATA_WIDTH-1:0] fifo_data_1,
  input  logic [DATA_WIDTH-1:0] fifo_data_2,
  input  logic [DATA_WIDTH-1:0] fifo_data_3,
  input  logic                  pause,
  output logic [3:0]            fifo_rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            dest_out,
  output logic                  idle,
  output logic                  error_out
);

  typedef enum logic [1:0] {StIdle, StRead, StError} state_e;

  localparam logic [3:0] BurstMax = 4'(BURST_LEN);

  state_e                  state_q, state_d;
  logic [1:0]              ch_q, ch_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [3:0]              burst_cnt_q, burst_cnt_d;
  logic [1:0]              sel_ch;
  logic                    pend_valid_q;
  logic [1:0]              pend_ch_q;
  logic [DATA_WIDTH-1:0]   pend_data;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [1:0]              dest_q;
  logic                    valid_q;
  logic                    error_q;
  logic                    any_err;
  logic                    pop;

  assign any_err = |fifo_error;

  // An error cycle must not pop: the word would be lost once the FSM parks in StError.
  assign pop = reset && (state_q == StRead) && !fifo_empty[ch_q] && !pause &&
               (burst_cnt_q < BurstMax) && !any_err;

  assign fifo_rd_enable = pop ? (4'b0001 << ch_q) : 4'b0000;

  // First non-empty channel starting at rr_ptr; iterate backwards so the nearest wins.
  always_comb begin
    logic [1:0] idx;
    sel_ch = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr_q + 2'(i);
      if (!fifo_empty[idx]) sel_ch = idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      StIdle: begin
        if (any_err) begin
          state_d = StError;
        end else if ((fifo_empty != 4'hf) && !pause) begin
          state_d     = StRead;
          ch_d        = sel_ch;
          burst_cnt_d = 4'd0;
        end
      end
      StRead: begin
        if (any_err) begin
          state_d = StError;
        end else if ((burst_cnt_q >= BurstMax) || (fifo_empty[ch_q] && !pause)) begin
          state_d  = StIdle;
          rr_ptr_d = ch_q + 2'd1;
        end else if (pop) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pend_data = fifo_data_0;
    unique case (pend_ch_q)
      2'd0: pend_data = fifo_data_0;
      2'd1: pend_data = fifo_data_1;
      2'd2: pend_data = fifo_data_2;
      2'd3: pend_data = fifo_data_3;
      default: pend_data = fifo_data_0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      ch_q         <= 2'd0;
      rr_ptr_q     <= 2'd0;
      burst_cnt_q  <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= 2'd0;
      data_q       <= '0;
      dest_q       <= 2'd0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      pend_valid_q <= pop;
      pend_ch_q    <= ch_q;
      valid_q      <= pend_valid_q;
      if (pend_valid_q) begin
        data_q <= pend_data;
        dest_q <= pend_ch_q;
      end
      error_q      <= error_q | (state_d == StError);
    end
  end

  assign data_out  = data_q;
  assign dest_out  = dest_q;
  assign valid_out = valid_q;
  assign error_out = error_q;
  assign idle      = (state_q == StIdle) && !pend_valid_q && !valid_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: behavioural upstream FIFOs with 1-cycle read data,
// expected words queued at pop time and compared when valid_out appears.
module tb_fifo_drain_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fifo_empty = 4'hf;
  logic [3:0] fifo_error = 4'h0;
  logic [5:0] fdata [4];
  logic       pause = 1'b0;
  logic [3:0] fifo_rd_enable;
  logic [5:0] data_out;
  logic       valid_out;
  logic [1:0] dest_out;
  logic       idle;
  logic       error_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5:0] fq [4][$];
  logic [7:0] sb [$];
  int pop_ch [$];
  int pop_cyc [$];
  int out_dest [$];
  int out_data [$];
  int out_cyc [$];

  fifo_drain_arbiter #(.DATA_WIDTH(6), .BURST_LEN(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_error     (fifo_error),
    .fifo_data_0    (fdata[0]),
    .fifo_data_1    (fdata[1]),
    .fifo_data_2    (fdata[2]),
    .fifo_data_3    (fdata[3]),
    .pause          (pause),
    .fifo_rd_enable (fifo_rd_enable),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .dest_out       (dest_out),
    .idle           (idle),
    .error_out      (error_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Upstream FIFO model and output monitor.
  always begin
    int pc;
    logic pv;
    @(negedge clk);
    pv = 1'b0;
    pc = 0;
    if (!reset) begin
      sb.delete();
    end else if (valid_out === 1'b1) begin
      n_checks++;
      out_dest.push_back(int'(dest_out));
      out_data.push_back(int'(data_out));
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got dest=%0d data=%h, required no output", dest_out,
                 data_out);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if ({dest_out, data_out} !== exp) begin
          n_fail++;
          $display("FAIL sb_word: got dest=%0d data=%h, required dest=%0d data=%h", dest_out,
                   data_out, exp[7:6], exp[5:0]);
        end
      end
    end
    if (fifo_rd_enable !== 4'b0000) begin
      for (int i = 0; i < 4; i++) if (fifo_rd_enable[i]) pc = i;
      n_checks++;
      if (!$onehot(fifo_rd_enable) || fq[pc].size() == 0) begin
        n_fail++;
        $display("FAIL pop_legal: got rd_enable=%b empty=%b, required one-hot on non-empty",
                 fifo_rd_enable, fifo_empty);
      end else begin
        pv = 1'b1;
        pop_ch.push_back(pc);
        pop_cyc.push_back(cyc);
        sb.push_back({2'(pc), fq[pc][0]});
      end
    end
    @(posedge clk);
    #1;
    if (pv) fdata[pc] = fq[pc].pop_front();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [5:0] w);
    fq[ch].push_back(w);
    fifo_empty[ch] = 1'b0;
  endtask

  task automatic clear_logs();
    pop_ch.delete();
    pop_cyc.delete();
    out_dest.delete();
    out_data.delete();
    out_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 300 && !(idle === 1'b1 && fifo_empty == 4'hf && sb.size() == 0 &&
                        fifo_rd_enable == 4'b0000)) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: got idle=%b empty=%b, required drained and idle", name,
               idle, fifo_empty);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    clear_logs();
    load(1, 6'h2a);
    repeat (3) begin
      tick();
      n_checks++;
      if (fifo_rd_enable !== 4'b0 || valid_out !== 1'b0 || data_out !== 6'h0 ||
          dest_out !== 2'd0 || error_out !== 1'b0 || idle !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state: got rd=%b v=%b d=%h dst=%0d err=%b idle=%b, required 0 0 0 0 0 1",
                 fifo_rd_enable, valid_out, data_out, dest_out, error_out, idle);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    wait_idle("reset");
    n_checks++;
    if (out_data.size() != 1 || out_data[0] != 'h2a || out_dest[0] != 1) begin
      n_fail++;
      $display("FAIL reset_drain: got %0d words, required 1 word 2a on ch1", out_data.size());
    end
  endtask

  task automatic test_single();
    clear_logs();
    load(2, 6'h15);
    wait_idle("single");
    n_checks++;
    if (pop_ch.size() != 1 || pop_ch[0] != 2) begin
      n_fail++;
      $display("FAIL single_pop: got %0d pops, required exactly 1 on ch2", pop_ch.size());
    end
    n_checks++;
    if (out_data.size() != 1 || out_data[0] != 'h15 || out_dest[0] != 2) begin
      n_fail++;
      $display("FAIL single_out: got %0d words, required one word 15 to dest 2", out_data.size());
    end else begin
      n_checks++;
      if (out_cyc[0] - pop_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL single_latency: got %0d, required 2", out_cyc[0] - pop_cyc[0]);
      end
    end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: got %b, required 1", idle);
    end
  endtask

  task automatic test_burst();
    bit ok;
    clear_logs();
    for (int i = 1; i <= 6; i++) load(0, 6'(i));
    wait_idle("burst");
    ok = (pop_ch.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (pop_ch[i] != 0) ok = 1'b0;
    if (ok) for (int i = 1; i < 4; i++) if (pop_cyc[i] != pop_cyc[0] + i) ok = 1'b0;
    if (ok && pop_cyc[4] - pop_cyc[3] < 2) ok = 1'b0;
    if (ok && pop_cyc[5] != pop_cyc[4] + 1) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL burst_pops: got %0d pops, required 4 back-to-back, gap, then 2 on ch0",
               pop_ch.size());
    end
    ok = (out_data.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (out_data[i] != i + 1) ok = 1'b0;
    if (ok) for (int i = 1; i < 4; i++) if (out_cyc[i] != out_cyc[0] + i) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d words, required 1..6 in order, first 4 consecutive",
               out_data.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_dest [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    bit ok;
    do_reset();
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      load(0, 6'(i));
      load(1, 6'(16 + i));
    end
    wait_idle("rr");
    ok = (out_dest.size() == 10);
    if (ok) for (int i = 0; i < 10; i++) if (out_dest[i] != exp_dest[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_order: got %0d words, required dest 0,0,0,0,1,1,1,1,0,1",
               out_dest.size());
    end
  endtask

  task automatic test_pause();
    int pops = 0;
    int n = 0;
    int rel;
    bit ok;
    clear_logs();
    for (int i = 0; i < 4; i++) load(3, 6'(33 + i));
    while (pops < 2 && n < 50) begin
      tick();
      if (fifo_rd_enable != 4'b0) pops++;
      n++;
    end
    @(posedge clk);
    #1 pause = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (fifo_rd_enable !== 4'b0) begin
        n_fail++;
        $display("FAIL pause_no_pop: got %b, required 0000", fifo_rd_enable);
      end
    end
    @(posedge clk);
    #1 pause = 1'b0;
    rel = cyc;
    n_checks++;
    if (out_data.size() != 2) begin
      n_fail++;
      $display("FAIL pause_inflight: got %0d words, required 2", out_data.size());
    end
    wait_idle("pause");
    ok = (pop_ch.size() == 4 && out_data.size() == 4);
    if (ok && (pop_cyc[2] < rel || pop_cyc[3] < rel)) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pause_resume: got %0d pops %0d words, required 4 and 4, last 2 after pause",
               pop_ch.size(), out_data.size());
    end
  endtask

  task automatic test_error();
    int n = 0;
    clear_logs();
    for (int i = 0; i < 4; i++) load(1, 6'(48 + i));
    while (fifo_rd_enable != 4'b0010 && n < 50) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1 fifo_error = 4'b1000;
    tick();
    n_checks++;
    if (fifo_rd_enable !== 4'b0) begin
      n_fail++;
      $display("FAIL error_stop: got %b, required 0000", fifo_rd_enable);
    end
    @(posedge clk);
    #1 fifo_error = 4'b0000;
    repeat (4) begin
      tick();
      n_checks++;
      if (fifo_rd_enable !== 4'b0 || error_out !== 1'b1) begin
        n_fail++;
        $display("FAIL error_sticky: got rd=%b err=%b, required 0000 1", fifo_rd_enable,
                 error_out);
      end
    end
    n_checks++;
    if (pop_ch.size() != 1 || out_data.size() != 1) begin
      n_fail++;
      $display("FAIL error_inflight: got %0d pops %0d words, required 1 and 1", pop_ch.size(),
               out_data.size());
    end
    do_reset();
    tick();
    n_checks++;
    if (error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: got %b, required 0", error_out);
    end
    wait_idle("error");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    load(2, 6'h05);
    wait_idle("mid_pre");
    clear_logs();
    for (int i = 0; i < 3; i++) load(3, 6'(10 + i));
    while (fifo_rd_enable == 4'b0 && n < 50) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    load(0, 6'h3f);
    tick();
    n_checks++;
    if (fifo_rd_enable !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_rd_gate: got %b, required 0000", fifo_rd_enable);
    end
    @(posedge clk);
    tick();
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 6'h0 || dest_out !== 2'd0 || error_out !== 1'b0 ||
        idle !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_vals: got v=%b d=%h dst=%0d err=%b idle=%b, required 0 0 0 0 1",
               valid_out, data_out, dest_out, error_out, idle);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release_valid: got %b, required 0", valid_out);
    end
    wait_idle("mid");
    n_checks++;
    if (pop_ch.size() != 4 || pop_ch[1] != 0 || out_data.size() != 3 || out_data[0] != 'h3f) begin
      n_fail++;
      $display("FAIL mid_rr_reset: got %0d pops %0d words, required first post-reset pop on ch0",
               pop_ch.size(), out_data.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) fdata[i] = 6'h0;
    test_reset();
    test_single();
    test_burst();
    test_round_robin();
    test_pause();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
